// File: rtl/mem_access_ctrl_if.sv
// Bundle of pipeline-side M-stage fields and memory-side handshake signals
// for the memory-stage access controller.
interface mem_access_ctrl_if;
  logic        memAccessM;
  logic        readEnM;
  logic        memWrtM;
  logic [15:0] aluOutM;
  logic [15:0] wrtDataM;
  logic        memDone;
  logic        memBusy;
  logic [15:0] memRdData;
  logic [15:0] memAddr;
  logic [15:0] memWrData;
  logic        memRd;
  logic        memWr;
  logic        Stall;
  logic [15:0] readDataM;
  logic        errM;
  logic [15:0] stallCount;

  // Controller side: consumes the M-stage fields and memory responses.
  modport master (
    input  memAccessM, readEnM, memWrtM, aluOutM, wrtDataM,
    input  memDone, memBusy, memRdData,
    output memAddr, memWrData, memRd, memWr, Stall, readDataM, errM, stallCount
  );

  // Environment side: pipeline register plus data memory.
  modport slave (
    output memAccessM, readEnM, memWrtM, aluOutM, wrtDataM,
    output memDone, memBusy, memRdData,
    input  memAddr, memWrData, memRd, memWr, Stall, readDataM, errM, stallCount
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one request at a time to a stalling
// data memory, stalls the pipeline until completion, flags misalign/timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.master  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] LP_LAST = 4'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        r_pend_rd, w_pend_rd_nxt;
  logic [15:0] r_rdata_q;
  logic [15:0] r_stall_cnt;

  logic w_valid, w_rd, w_wr, w_stall, w_err, w_ld_done;

  assign w_valid = bus.memAccessM & (bus.readEnM | bus.memWrtM);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_pend_rd_nxt  = r_pend_rd;
    w_rd           = 1'b0;
    w_wr           = 1'b0;
    w_stall        = 1'b0;
    w_err          = 1'b0;
    w_ld_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          if (bus.aluOutM[0]) begin
            w_err = 1'b1;
          end else if (bus.memBusy) begin
            w_stall = 1'b1;
          end else begin
            // A simultaneous read+write request is a store.
            w_wr = bus.memWrtM;
            w_rd = bus.readEnM & ~bus.memWrtM;
            if (bus.memDone) begin
              w_ld_done = w_rd;
            end else begin
              w_stall        = 1'b1;
              w_state_nxt    = S_WAIT;
              w_wait_cnt_nxt = 4'd0;
              w_pend_rd_nxt  = w_rd;
            end
          end
        end
      end
      S_WAIT: begin
        if (bus.memDone) begin
          w_ld_done   = r_pend_rd;
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt < LP_LAST) begin
          w_stall        = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end else begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Reset overrides every pipeline-visible output combinationally.
    if (!rst) begin
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      w_stall   = 1'b0;
      w_err     = 1'b0;
      w_ld_done = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_pend_rd   <= 1'b0;
      r_rdata_q   <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_pend_rd  <= w_pend_rd_nxt;
      if (w_ld_done) begin
        r_rdata_q <= bus.memRdData;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign bus.memAddr    = bus.aluOutM;
  assign bus.memWrData  = bus.wrtDataM;
  assign bus.memRd      = w_rd;
  assign bus.memWr      = w_wr;
  assign bus.Stall      = w_stall;
  assign bus.errM       = w_err;
  assign bus.readDataM  = w_ld_done ? bus.memRdData : r_rdata_q;
  assign bus.stallCount = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one optional outstanding transaction with its age in
  // cycles since the request; a late completion is lost once age hits TO.
  bit          m_out;
  bit          m_load;
  int          m_age;
  logic [15:0] m_rdq;
  int          m_cnt;

  bit e_rd, e_wr, e_stall, e_err, e_ldone, e_issue_miss;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out  = 1'b0;
    m_load = 1'b0;
    m_age  = 0;
    m_rdq  = 16'h0000;
    m_cnt  = 0;
  endtask

  task automatic model_eval();
    bit valid;
    e_rd = 0; e_wr = 0; e_stall = 0; e_err = 0; e_ldone = 0; e_issue_miss = 0;
    valid = bus.memAccessM && (bus.readEnM || bus.memWrtM);
    if (!rst) begin
      // everything held at zero
    end else if (m_out) begin
      if (bus.memDone)   e_ldone = m_load;
      else if (m_age < TO) e_stall = 1;
      else               e_err = 1;
    end else if (valid) begin
      if (bus.aluOutM[0]) e_err = 1;
      else if (bus.memBusy) e_stall = 1;
      else begin
        e_wr = bus.memWrtM;
        e_rd = !bus.memWrtM;
        if (bus.memDone) e_ldone = e_rd;
        else begin
          e_stall = 1;
          e_issue_miss = 1;
        end
      end
    end
  endtask

  task automatic model_step(input logic [15:0] rdata, input bit done);
    if (!rst) begin
      model_reset();
      return;
    end
    if (e_ldone) m_rdq = rdata;
    if (e_stall && m_cnt < 16'hFFFF) m_cnt++;
    if (m_out) begin
      if (done || m_age >= TO) m_out = 0;
      else m_age++;
    end else if (e_issue_miss) begin
      m_out  = 1;
      m_age  = 1;
      m_load = e_rd;
    end
  endtask

  task automatic drive_cycle(input bit acc, input bit rd, input bit wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input bit done, input bit busy, input logic [15:0] rdata);
    @(negedge clk);
    bus.memAccessM = acc;
    bus.readEnM    = rd;
    bus.memWrtM    = wr;
    bus.aluOutM    = addr;
    bus.wrtDataM   = wdata;
    bus.memDone    = done;
    bus.memBusy    = busy;
    bus.memRdData  = rdata;
    #1;
    model_eval();
    check("memRd",      16'(bus.memRd),  16'(e_rd));
    check("memWr",      16'(bus.memWr),  16'(e_wr));
    check("Stall",      16'(bus.Stall),  16'(e_stall));
    check("errM",       16'(bus.errM),   16'(e_err));
    check("readDataM",  bus.readDataM,   e_ldone ? rdata : m_rdq);
    check("stallCount", bus.stallCount,  16'(m_cnt));
    check("memAddr",    bus.memAddr,     addr);
    check("memWrData",  bus.memWrData,   wdata);
    @(posedge clk);
    model_step(rdata, done);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    // Reset forces outputs low even with a load hit presented.
    drive_cycle(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h1111);
    #2 rst = 1'b1;

    // Load hit, then readDataM holds the captured value.
    drive_cycle(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'hBEEF);
    drive_cycle(0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h7777);
    check("hit_hold", bus.readDataM, 16'hBEEF);

    // Store miss completing after 3 cycles.
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1, 16'h0020, 16'h1234, 0, 0, 16'h0);
    drive_cycle(1, 0, 1, 16'h0020, 16'h1234, 1, 0, 16'h0);
    drive_cycle(0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0);
    check("store_miss_cnt", bus.stallCount, 16'd3);

    // Busy retry.
    drive_cycle(1, 1, 0, 16'h0040, 16'h0, 0, 1, 16'h0);
    drive_cycle(1, 1, 0, 16'h0040, 16'h0, 0, 1, 16'h0);
    drive_cycle(1, 1, 0, 16'h0040, 16'h0, 1, 0, 16'hA5A5);

    // Misaligned load.
    drive_cycle(1, 1, 0, 16'h0021, 16'h0, 0, 0, 16'h0);
    drive_cycle(0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0);

    // Timeout, then a late memDone that must not update readDataM.
    for (int i = 0; i < TO + 1; i++) drive_cycle(1, 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0);
    drive_cycle(0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'hDEAD);
    check("late_done", bus.readDataM, 16'hA5A5);

    // Both read and write set: treated as a store hit.
    drive_cycle(1, 1, 1, 16'h0050, 16'h5555, 1, 0, 16'h9999);

    // Reset two cycles into WAIT.
    drive_cycle(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0);
    drive_cycle(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0);
    drive_cycle(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0);
    #2 rst = 1'b0;
    #1;
    check("rst_stall", 16'(bus.Stall), 16'd0);
    check("rst_cnt",   bus.stallCount, 16'd0);
    model_reset();
    drive_cycle(1, 1, 0, 16'h0060, 16'h0, 1, 0, 16'h2222);
    #2 rst = 1'b1;
    drive_cycle(0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h3333);
    drive_cycle(1, 1, 0, 16'h0062, 16'h0, 1, 0, 16'h5A5A);
    drive_cycle(0, 0, 0, 16'h0000, 16'h0, 0, 0, 16'h0);
    check("post_rst_load", bus.readDataM, 16'h5A5A);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] addr;
      addr = 16'($urandom);
      if ($urandom_range(3) != 0) addr[0] = 1'b0;
      drive_cycle(bit'($urandom_range(2) != 0), bit'($urandom), bit'($urandom),
                  addr, 16'($urandom),
                  bit'($urandom_range(2) == 0), bit'($urandom_range(3) == 0),
                  16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller: the consumer end of the execute-to-memory pipeline register. It takes the memory-op fields latched into the M stage, drives a stalling data memory with a request/done handshake, and generates the `Stall` that freezes the execute-to-memory register and all upstream stages until the access completes. It also flags misaligned and timed-out accesses, and counts stall cycles for performance reporting.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in WAIT before the access is abandoned (1..15).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `memAccessM`  in  1  the M-stage instruction is a load or store.
- `readEnM`  in  1  the M-stage access is a load.
- `memWrtM`  in  1  the M-stage access is a store.
- `aluOutM`  in  16  byte address.
- `wrtDataM`  in  16  store data.
- `memDone`  in  1  memory completed the outstanding request this cycle.
- `memBusy`  in  1  memory refuses a new request this cycle.
- `memRdData`  in  16  load data, valid when `memDone`=1.
- `memAddr`  out  16  address to memory; equals `aluOutM`.
- `memWrData`  out  16  store data to memory; equals `wrtDataM`.
- `memRd` / `memWr`  out  1  one-cycle request strobes.
- `Stall`  out  1  hold the execute-to-memory register and earlier stages.
- `readDataM`  out  16  load result to writeback.
- `errM`  out  1  one-cycle error pulse (misaligned or timeout).
- `stallCount`  out  16  saturating count of `Stall`=1 cycles.

## Operation
- The FSM has two states, IDLE and WAIT. State, `rdataQ`, the wait counter `waitCnt` (4-bit), and `stallCount` are all registers.
- Valid access: `memAccessM & (readEnM | memWrtM)`. An access is misaligned when `aluOutM[0]`=1.
- **IDLE, no valid access:** strobes 0, `Stall`=0, `errM`=0.
- **IDLE, misaligned access:**
  - `errM`=1 and `Stall`=0 in the same cycle.
  - No strobe is issued, and the state stays IDLE.
- **IDLE, aligned access:**
  - `memRd`=`readEnM` and `memWr`=`memWrtM`, qualified by `!memBusy`.
  - If `memBusy`=1: no strobe, `Stall`=1, stay in IDLE, and re-attempt next cycle.
  - If the strobe is issued and `memDone`=1 in the same cycle (hit): `Stall`=0 and stay in IDLE.
  - If the strobe is issued and `memDone`=0: `Stall`=1, go to WAIT, and clear `waitCnt`.
- **WAIT:**
  - Strobes are 0.
  - On `memDone`=1: `Stall`=0 and go to IDLE.
  - Otherwise, while `waitCnt` < `TIMEOUT`-1: `Stall`=1 and increment `waitCnt`.
  - Otherwise (timeout): `Stall`=0, `errM`=1, go to IDLE. A `memDone` that arrives later in IDLE is ignored.
- **Read data:**
  - `readDataM` = `memRdData` in a cycle where `memDone`=1 completes a load.
  - Otherwise `readDataM` = `rdataQ`, which captures `memRdData` on each such load completion.
- `memDone` in IDLE without a same-cycle strobe is ignored: no state change and no capture.
- `stallCount` increments in every cycle where `Stall`=1, and saturates at 0xFFFF.
- If both `readEnM` and `memWrtM` are 1, the access is treated as a store: `memWr`=1 and `memRd`=0.

## Timing
- **Reset:** while `rst`=0, state=IDLE, `waitCnt`=0, `rdataQ`=0, `stallCount`=0.
  - `Stall`, `memRd`, `memWr`, `errM` are forced to 0 and `readDataM`=0, regardless of other inputs.
  - Any outstanding memory request is abandoned.
- **Hit latency:** 0 added cycles; `Stall` never asserts.
- **Miss latency:** `Stall` is high from the request cycle through the cycle before `memDone`. It falls combinationally in the `memDone` cycle, so the pipeline advances on that cycle's edge.
- **Strobe spacing:** strobes last exactly one cycle per accepted request. There is never more than one outstanding request.
- **Next access:** a new access can be accepted in the cycle immediately after `memDone`.
- **Reset mid-WAIT:** leaves WAIT immediately and asynchronously. The first post-reset `memDone` is ignored.
- **Combinational paths:** `memAddr`, `memWrData`, `Stall`, `errM`, and `readDataM` are combinational from the inputs plus state. No combinational path runs from `memDone` to `memRd`/`memWr`.

## Test plan
- **Load hit:** `memAccessM`=1, `readEnM`=1, `aluOutM`=0x0010, with `memDone`=1 and `memRdData`=0xBEEF in the same cycle → `memRd` pulses once, `Stall`=0, `readDataM`=0xBEEF, and `readDataM` stays 0xBEEF afterward.
- **Store miss:** `memWrtM`=1, `aluOutM`=0x0020, `wrtDataM`=0x1234, `memDone` after 3 cycles → `memWr` is high only in cycle 0, `Stall`=1 for cycles 0–2 and 0 in cycle 3, `stallCount`=3.
- **Busy retry:** `memBusy`=1 for 2 cycles, then 0 with `memDone`=1 → no strobe for 2 cycles with `Stall`=1, then one `memRd` with `Stall`=0.
- **Misaligned:** `aluOutM`=0x0021 load → `errM`=1 for one cycle, no strobe, `Stall`=0.
- **Timeout:** `TIMEOUT`=4, `memDone` never asserted → `Stall` is high for 4 cycles, then `errM`=1 with `Stall`=0. A late `memDone` leaves `readDataM` unchanged.
- **Reset mid-WAIT:** assert `rst`=0 two cycles into WAIT → `Stall` drops immediately and `stallCount`=0. After release, an immediate `memDone` is ignored and the next load completes normally.
